// File: rtl/cnn_layer_scheduler.sv
// rtl/cnn_layer_scheduler.sv - batch sequencer: weight preload, then conv and pool per image (optional watchdog: CNN_SCHED_WATCHDOG_EN)
module cnn_layer_scheduler #(
    parameter int TOTAL_IMAGE     = 4,
    parameter int WATCHDOG_CYCLES = 1024,
    localparam int IMG_WIDTH      = (TOTAL_IMAGE > 1) ? $clog2(TOTAL_IMAGE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 weight_load_done,
    input  logic                 conv_image_fin,
    input  logic                 pool_fin,
    output logic                 weight_load_req,
    output logic                 conv_enable,
    output logic                 pool_enable,
    output logic [IMG_WIDTH-1:0] image_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_CONV,
        S_POOL,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [IMG_WIDTH-1:0] LAST_IMG = IMG_WIDTH'(TOTAL_IMAGE - 1);

    state_t                state;
    state_t                state_next;
    logic [IMG_WIDTH-1:0]  idx_next;
    logic                  in_wait;

    assign in_wait = (state == S_WLOAD) || (state == S_CONV) || (state == S_POOL);

`ifdef CNN_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_next;
    logic            wd_expired;

    assign wd_expired = in_wait && (wd_cnt == WD_MAX);

    // Dwell counter: cleared on every state change, counts only while waiting on a layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state_next != state) begin
            wd_cnt <= '0;
        end else if (in_wait && (wd_cnt != WD_MAX)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Sticky timeout flag, cleared only when a new batch is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else begin
            error <= err_next;
        end
    end
`else
    assign error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and image counter; abort outranks the watchdog, which outranks fin pulses.
    always_comb begin
        state_next = state;
        idx_next   = image_idx;
`ifdef CNN_SCHED_WATCHDOG_EN
        err_next   = error;
`endif
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_WLOAD;
                        idx_next   = '0;
`ifdef CNN_SCHED_WATCHDOG_EN
                        err_next   = 1'b0;
`endif
                    end
                end
                S_WLOAD: if (weight_load_done) state_next = S_CONV;
                S_CONV:  if (conv_image_fin)   state_next = S_POOL;
                S_POOL: begin
                    if (pool_fin) begin
                        state_next = (image_idx == LAST_IMG) ? S_DONE : S_NEXT;
                    end
                end
                S_NEXT: begin
                    state_next = S_CONV;
                    idx_next   = image_idx + IMG_WIDTH'(1);
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
`ifdef CNN_SCHED_WATCHDOG_EN
            if (wd_expired) begin
                state_next = S_IDLE;
                err_next   = 1'b1;
            end
`endif
        end
    end

    // Registered outputs, decoded from the state being entered so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_load_req <= 1'b0;
            conv_enable     <= 1'b0;
            pool_enable     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            image_idx       <= '0;
        end else begin
            weight_load_req <= (state_next == S_WLOAD);
            conv_enable     <= (state_next == S_CONV);
            pool_enable     <= (state_next == S_POOL);
            busy            <= (state_next != S_IDLE);
            done            <= (state_next == S_DONE);
            image_idx       <= idx_next;
        end
    end

endmodule
